// File: rtl/regulator_trim_calibrator_if.sv
// ---------------------------------------------------------------------------
// regulator_trim_calibrator_if
//
// Groups the control, comparator and result signals of the regulator trim
// calibrator into one bundle.
//
//   start      begin a calibration (sampled only while the engine is idle)
//   abort      cancel a calibration in progress
//   vout_high  comparator flag, 1 = vout above target, synchronous to clk
//   trim       signed trim code driven to the regulator
//   busy       engine is not idle
//   done       one-cycle pulse when a calibration completes
//   cal_valid  trim holds a completed calibration result
//   sat_hi     final code is the most positive trim
//   sat_lo     final code is the most negative trim
//
// Modports:
//   master  system / test side: drives start, abort, vout_high
//   slave   calibrator side: drives trim and the status flags
// ---------------------------------------------------------------------------
interface regulator_trim_calibrator_if #(
  parameter int TRIM_WIDTH = 4
);
  logic                         start;
  logic                         abort;
  logic                         vout_high;
  logic signed [TRIM_WIDTH-1:0] trim;
  logic                         busy;
  logic                         done;
  logic                         cal_valid;
  logic                         sat_hi;
  logic                         sat_lo;

  modport master (
    output start, abort, vout_high,
    input  trim, busy, done, cal_valid, sat_hi, sat_lo
  );

  modport slave (
    input  start, abort, vout_high,
    output trim, busy, done, cal_valid, sat_hi, sat_lo
  );
endinterface

// File: rtl/regulator_trim_calibrator.sv
// ---------------------------------------------------------------------------
// regulator_trim_calibrator
//
// Closed-loop SAR trim engine for the regulator. Starting from mid-scale it
// tries each trim bit from MSB to LSB, waits SETTLE_CYCLES after every trim
// update, samples the comparator and keeps the bit when vout is not above
// target. The final code is the largest code for which vout_high = 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        regulator_trim_calibrator_if.slave (start/abort/vout_high in,
//              trim/busy/done/cal_valid/sat_hi/sat_lo out)
//   dbg_state  current FSM state (0 IDLE, 1 SETTLE, 2 SAMPLE)
//
// Parameters:
//   TRIM_WIDTH     width of the signed trim code
//   SETTLE_CYCLES  cycles spent in SETTLE after each trim update (>= 1)
//   RESET_TRIM     signed trim value driven out of reset
//
// Build option:
//   TRIM_CAL_MAJORITY_EN  when defined, SAMPLE lasts 3 cycles and each bit
//                         decision is the 2-of-3 majority of the comparator.
//
// Handshake: start is a level request with no ready; it is acted on only
// in IDLE (busy = 0) and ignored otherwise. abort has priority over start in
// IDLE (nothing happens) and, while busy, returns to IDLE on the next edge
// restoring the trim that was in place before the calibration began.
// ---------------------------------------------------------------------------
module regulator_trim_calibrator #(
  parameter int TRIM_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int RESET_TRIM    = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  regulator_trim_calibrator_if.slave        bus,
  output logic [1:0]                        dbg_state
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BIT_W = (TRIM_WIDTH > 1) ? $clog2(TRIM_WIDTH) : 1;

  localparam logic [TRIM_WIDTH-1:0] ONE         = TRIM_WIDTH'(1);
  localparam logic [TRIM_WIDTH-1:0] OFFSET      = ONE << (TRIM_WIDTH - 1);
  localparam logic [TRIM_WIDTH-1:0] RESET_CODE  = TRIM_WIDTH'(RESET_TRIM);
  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0]      TOP_BIT     = BIT_W'(TRIM_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  // result holds only the bits already decided, in offset (unsigned) form
  logic [TRIM_WIDTH-1:0] result_q, result_d;
  logic [TRIM_WIDTH-1:0] restore_q, restore_d;
  // trim is kept as raw two's-complement bits
  logic [TRIM_WIDTH-1:0] trim_q, trim_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  sat_hi_q, sat_hi_d;
  logic                  sat_lo_q, sat_lo_d;

  logic [TRIM_WIDTH-1:0] mask;
  logic [TRIM_WIDTH-1:0] next_mask;
  logic [TRIM_WIDTH-1:0] decided;
  logic                  vote_high;

`ifdef TRIM_CAL_MAJORITY_EN
  // phase counts closing edges already spent in SAMPLE; the first two
  // comparator samples are stored, the third is used live in the vote.
  logic [1:0] phase_q, phase_d;
  logic [1:0] smp_q, smp_d;

  assign vote_high = (smp_q[0] & smp_q[1]) |
                     (smp_q[0] & bus.vout_high) |
                     (smp_q[1] & bus.vout_high);
`else
  assign vote_high = bus.vout_high;
`endif

  assign mask      = ONE << bit_q;
  assign next_mask = ONE << (bit_q - BIT_W'(1));
  // vout above target means the trial code is too high: drop the bit
  assign decided   = vote_high ? (result_q & ~mask) : (result_q | mask);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    result_d  = result_q;
    restore_d = restore_q;
    trim_d    = trim_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    sat_hi_d  = sat_hi_q;
    sat_lo_d  = sat_lo_q;
`ifdef TRIM_CAL_MAJORITY_EN
    phase_d   = phase_q;
    smp_d     = smp_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          restore_d = trim_q;
          result_d  = '0;
          bit_d     = TOP_BIT;
          // first trial is the MSB alone, which is offset code = trim 0
          trim_d    = OFFSET - OFFSET;
          valid_d   = 1'b0;
          sat_hi_d  = 1'b0;
          sat_lo_d  = 1'b0;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        if (bus.abort) begin
          state_d  = IDLE;
          trim_d   = restore_q;
          valid_d  = 1'b0;
          sat_hi_d = 1'b0;
          sat_lo_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
`ifdef TRIM_CAL_MAJORITY_EN
          phase_d = 2'd0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (bus.abort) begin
          state_d  = IDLE;
          trim_d   = restore_q;
          valid_d  = 1'b0;
          sat_hi_d = 1'b0;
          sat_lo_d = 1'b0;
        end
`ifdef TRIM_CAL_MAJORITY_EN
        else if (phase_q != 2'd2) begin
          smp_d[phase_q[0]] = bus.vout_high;
          phase_d           = phase_q + 2'd1;
        end
`endif
        else begin
          result_d = decided;
          if (bit_q != '0) begin
            bit_d   = bit_q - BIT_W'(1);
            trim_d  = (decided | next_mask) - OFFSET;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end else begin
            trim_d   = decided - OFFSET;
            done_d   = 1'b1;
            valid_d  = 1'b1;
            sat_hi_d = &decided;
            sat_lo_d = ~|decided;
            state_d  = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      result_q  <= '0;
      restore_q <= RESET_CODE;
      trim_q    <= RESET_CODE;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
`ifdef TRIM_CAL_MAJORITY_EN
      phase_q   <= 2'd0;
      smp_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      result_q  <= result_d;
      restore_q <= restore_d;
      trim_q    <= trim_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      sat_hi_q  <= sat_hi_d;
      sat_lo_q  <= sat_lo_d;
`ifdef TRIM_CAL_MAJORITY_EN
      phase_q   <= phase_d;
      smp_q     <= smp_d;
`endif
    end
  end

  assign bus.trim      = $signed(trim_q);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.cal_valid = valid_q;
  assign bus.sat_hi    = sat_hi_q;
  assign bus.sat_lo    = sat_lo_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_regulator_trim_calibrator.sv
// ---------------------------------------------------------------------------
// tb_regulator_trim_calibrator
//
// Directed bench for regulator_trim_calibrator with a behavioural comparator
// model (vout_high as a function of trim). Expected trial-trim sequences are
// queued per run and popped on entry to each SAMPLE window.
// ---------------------------------------------------------------------------
module tb_regulator_trim_calibrator;

  localparam int TW = 4;
  localparam int SC = 16;
`ifdef TRIM_CAL_MAJORITY_EN
  localparam int SAMPLE_LEN = 3;
`else
  localparam int SAMPLE_LEN = 1;
`endif
  localparam int LATENCY = TW * (SC + SAMPLE_LEN);
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;

  regulator_trim_calibrator_if #(.TRIM_WIDTH(TW)) bus ();

  regulator_trim_calibrator #(
    .TRIM_WIDTH   (TW),
    .SETTLE_CYCLES(SC),
    .RESET_TRIM   (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // comparator model: 0 trim>3, 1 always high, 2 always low, 3 trim>-2
  int   mode     = 0;
  bit   inj_en   = 1'b0;
  int   samp_run = 0;
  logic vh;
  logic inject;

  always_comb begin
    case (mode)
      0:       vh = ($signed(bus.trim) > 3);
      1:       vh = 1'b1;
      2:       vh = 1'b0;
      default: vh = ($signed(bus.trim) > -2);
    endcase
  end

  // flips the middle sample of each SAMPLE window when enabled
  always @(posedge clk) samp_run <= (dbg_state == ST_SAMPLE) ? samp_run + 1 : 0;
  assign inject        = inj_en && (dbg_state == ST_SAMPLE) && (samp_run == 1);
  assign bus.vout_high = vh ^ inject;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic load_seq(input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic [TW-1:0] c, input logic [TW-1:0] d);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  // Starts a calibration and follows it to done (or the budget). Extra start
  // pulses are driven at cycles restart_a/restart_b. lat counts edges from
  // the edge that accepted start to the edge that raised done.
  task automatic run_cal(input int restart_a, input int restart_b, input int budget,
                         output int lat, output bit saw_done);
    bit prev_sample;
    int exp_t;
    lat = 0;
    saw_done = 1'b0;
    prev_sample = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (lat < budget && !saw_done) begin
      bus.start = (lat == restart_a) || (lat == restart_b);
      @(posedge clk);
      lat++;
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        saw_done = 1'b1;
      end else if (dbg_state == ST_SAMPLE && !prev_sample) begin
        if (exp_q.size() != 0) exp_t = $signed(exp_q.pop_front());
        else exp_t = 99;
        check("trim_seq", int'(bus.trim), exp_t);
      end
      prev_sample = (dbg_state == ST_SAMPLE);
    end
  endtask

  task automatic check_result(input string tag, input int lat, input bit saw_done,
                              input int exp_trim, input bit exp_hi, input bit exp_lo);
    check({tag, "_done"},      int'(saw_done), 1);
    check({tag, "_latency"},   lat, LATENCY);
    check({tag, "_trim"},      int'(bus.trim), exp_trim);
    check({tag, "_cal_valid"}, int'(bus.cal_valid), 1);
    check({tag, "_sat_hi"},    int'(bus.sat_hi), int'(exp_hi));
    check({tag, "_sat_lo"},    int'(bus.sat_lo), int'(exp_lo));
    check({tag, "_seq_left"},  exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  saw;
    int  changes;

    bus.start = 1'b0;
    bus.abort = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_trim",      int'(bus.trim), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_done",      int'(bus.done), 0);
    check("rst_cal_valid", int'(bus.cal_valid), 0);
    check("rst_sat_hi",    int'(bus.sat_hi), 0);
    check("rst_sat_lo",    int'(bus.sat_lo), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle hold: nothing moves for 100 cycles
    changes = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (bus.trim != 0 || bus.busy || bus.done || bus.cal_valid) changes++;
    end
    check("idle_changes",   changes, 0);
    check("idle_trim",      int'(bus.trim), 0);
    check("idle_busy",      int'(bus.busy), 0);
    check("idle_cal_valid", int'(bus.cal_valid), 0);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", int'(bus.busy), 0);

    // main calibration, vout_high = trim > 3: trials 0,4,2,3 -> 3
    mode = 0;
    load_seq(4'd0, 4'd4, 4'd2, 4'd3);
    run_cal(-1, -1, 200, lat, saw);
    check_result("main", lat, saw, 3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("main_done_pulse", int'(bus.done), 0);

    // extra start pulses while busy change nothing
    load_seq(4'd0, 4'd4, 4'd2, 4'd3);
    run_cal(10, 40, 200, lat, saw);
    check_result("restart", lat, saw, 3, 1'b0, 1'b0);

    // abort in second SETTLE: trials 0 (high) then -4; restore to 3
    mode = 3;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_pre_trim",  int'(bus.trim), -4);
    check("abort_pre_busy",  int'(bus.busy), 1);
    check("abort_pre_valid", int'(bus.cal_valid), 0);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_trim",      int'(bus.trim), 3);
    check("abort_busy",      int'(bus.busy), 0);
    check("abort_cal_valid", int'(bus.cal_valid), 0);
    saw = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.done) saw = 1'b1;
    end
    check("abort_no_done", int'(saw), 0);

    // all high -> minimum code
    mode = 1;
    load_seq(4'd0, 4'hC, 4'hA, 4'h9);
    run_cal(-1, -1, 200, lat, saw);
    check_result("sat_low", lat, saw, -8, 1'b0, 1'b1);

    // all low -> maximum code
    mode = 2;
    load_seq(4'd0, 4'd4, 4'd6, 4'd7);
    run_cal(-1, -1, 200, lat, saw);
    check_result("sat_high", lat, saw, 7, 1'b1, 1'b0);

`ifdef TRIM_CAL_MAJORITY_EN
    // one of three samples inverted in each window; majority still -> 3
    mode = 0;
    inj_en = 1'b1;
    load_seq(4'd0, 4'd4, 4'd2, 4'd3);
    run_cal(-1, -1, 200, lat, saw);
    inj_en = 1'b0;
    check_result("majority", lat, saw, 3, 1'b0, 1'b0);
`endif

    // async reset mid-calibration (trial trim is 4 at cycle 30)
    mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("midrst_pre_busy", int'(bus.busy), 1);
    check("midrst_pre_trim", int'(bus.trim), 4);
    rst_n = 1'b0;
    #1;
    check("midrst_trim",      int'(bus.trim), 0);
    check("midrst_busy",      int'(bus.busy), 0);
    check("midrst_done",      int'(bus.done), 0);
    check("midrst_cal_valid", int'(bus.cal_valid), 0);
    check("midrst_sat_hi",    int'(bus.sat_hi), 0);
    check("midrst_sat_lo",    int'(bus.sat_lo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regulator_trim_calibrator.md
Name: regulator_trim_calibrator

Overview:
- Closed-loop digital trim engine for the mixed-signal regulator: drives the regulator's signed trim code and reads back a comparator flag indicating whether vout exceeds its target.
- Runs a successive-approximation (SAR) search over the full signed trim range, waits a programmable settling time after every trim change, and holds the final calibrated code on its output.
- Sits between the regulator's trim input and the analog comparator output (wreal domain → logic).

Parameters:
- TRIM_WIDTH, 4, width of signed trim code; range -2^(TRIM_WIDTH-1) .. 2^(TRIM_WIDTH-1)-1
- SETTLE_CYCLES, 16, clock cycles spent in SETTLE after each trim update; legal range ≥1
- RESET_TRIM, 0, signed trim value driven out of reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin calibration; sampled only in IDLE
- abort  input  1  cancel calibration in progress
- vout_high  input  1  comparator: 1 = vout above target, already synchronous to clk
- trim  output  TRIM_WIDTH  signed trim code to regulator
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse on successful completion
- cal_valid  output  1  level: trim holds a completed calibration result
- sat_hi  output  1  final code = max (target possibly out of range high)
- sat_lo  output  1  final code = min

Behaviour:
- Reset (async assert, sync deassert assumed at the system level): trim=RESET_TRIM, busy=0, done=0, cal_valid=0, sat_hi=0, sat_lo=0, state=IDLE.
- Internal offset code u = trim + 2^(TRIM_WIDTH-1), unsigned. Trim increases vout monotonically.
- States: IDLE, SETTLE, SAMPLE.
- IDLE: on start=1 → save current trim as restore value, clear result reg, bit index b=TRIM_WIDTH-1, trim ← (result | 1<<b) - 2^(TRIM_WIDTH-1), cal_valid←0, sat_*←0, go SETTLE with counter=SETTLE_CYCLES-1.
- SETTLE: lasts exactly SETTLE_CYCLES cycles (counter decrements to 0), then → SAMPLE.
- SAMPLE: 1 cycle; at its closing edge:
  - if vout_high=0, keep bit b set in the result; else clear it.
  - If b>0: b←b-1, trim ← (result | 1<<b) - offset, → SETTLE.
  - If b=0: trim ← final result - offset, done=1 for 1 cycle, cal_valid←1, sat_hi=(u=all ones), sat_lo=(u=0), → IDLE.
- Latency: start edge to done high = TRIM_WIDTH*(SETTLE_CYCLES+1) cycles (68 with defaults).
- start while busy: ignored. start and abort same cycle in IDLE: abort wins, no action.
- abort while busy (any state): next edge → IDLE, trim ← restore value, cal_valid=0, sat_*=0, no done pulse. abort in IDLE: no effect.
- Reset mid-calibration: immediate return to reset values; the restore value is discarded.
- Result: largest code with vout_high=0 under monotonic comparator; all-high → min code, all-low → max code.
- trim is registered; it changes only on IDLE→SETTLE, SAMPLE edges, abort, or reset.

Optional Feature:
- Macro TRIM_CAL_MAJORITY_EN.
- Defined: SAMPLE lasts 3 cycles; vout_high is captured on each closing edge and the bit decision uses the 2-of-3 majority.
- Per-bit time becomes SETTLE_CYCLES+3 cycles; latency is TRIM_WIDTH*(SETTLE_CYCLES+3) (76 default).
- abort is honoured in any of the 3 cycles.
- Undefined: single-sample decision as above.

Test Plan:
- Reset then idle: trim=0, busy=0, cal_valid=0; hold 100 cycles → no change.
- Comparator model vout_high=(trim>3), start pulse:
  - trim sequence 0,4,2,3, then final 3.
  - done exactly 68 cycles after start; cal_valid=1, sat_hi=sat_lo=0.
- Saturation:
  - vout_high=1 constant → final trim=-8, sat_lo=1.
  - vout_high=0 constant → final trim=7, sat_hi=1.
- Abort:
  - Calibrate to 3.
  - New start with vout_high=(trim>-2); abort during second SETTLE → trim returns to 3 next cycle, cal_valid=0, no done pulse.
- Start during busy: extra start pulses mid-calibration → result and latency identical to the undisturbed run. Async reset at cycle 30 → all outputs at reset values immediately.
- TRIM_CAL_MAJORITY_EN:
  - vout_high=(trim>3), with 1-of-3 samples inverted in each SAMPLE window → final trim=3.
  - done 76 cycles after start.
